// File: rtl/miriscv_decode_pkg.sv
// Shared decode/LSU definitions: memory access size codes, LSU FSM states and byte-enable patterns.
package miriscv_decode_pkg;

    localparam logic [2:0] MEM_ACCESS_WORD  = 3'd0;
    localparam logic [2:0] MEM_ACCESS_HALF  = 3'd1;
    localparam logic [2:0] MEM_ACCESS_BYTE  = 3'd2;
    localparam logic [2:0] MEM_ACCESS_UHALF = 3'd3;
    localparam logic [2:0] MEM_ACCESS_UBYTE = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } lsu_state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    // Unused size codes (5-7) behave as full-word accesses.
    function automatic logic [2:0] norm_size(input logic [2:0] size);
        return (size > MEM_ACCESS_UBYTE) ? MEM_ACCESS_WORD : size;
    endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// Combinational data alignment for the LSU: store byte enables / lane replication and
// load byte/half extraction with sign or zero extension.
module miriscv_lsu_align
    import miriscv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      size,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        be        = BE_WORD;
        wdata_rep = wdata;
        rdata_ext = rdata;
        byte_s    = rdata[{addr_lo, 3'b000} +: 8];
        half_s    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (norm_size(size))
            MEM_ACCESS_HALF: begin
                be        = addr_lo[1] ? (BE_HALF << 2) : BE_HALF;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = XLEN'(half_s);
            end
            MEM_ACCESS_UHALF: begin
                be        = addr_lo[1] ? (BE_HALF << 2) : BE_HALF;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = XLEN'(unsigned'(half_s));
            end
            MEM_ACCESS_BYTE: begin
                be        = BE_BYTE << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = XLEN'(byte_s);
            end
            MEM_ACCESS_UBYTE: begin
                be        = BE_BYTE << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = XLEN'(unsigned'(byte_s));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: one outstanding req/gnt/rvalid transaction, pipeline stall and kill/drain handling.
// Build option MIRISCV_LSU_MISALIGN_TRAP_EN: misaligned word/half accesses raise lsu_misalign_o instead of issuing.
module miriscv_lsu
    import miriscv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [2:0]      lsu_size_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic            lsu_kill_i,
    output logic            lsu_stall_o,
    output logic            lsu_rvalid_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            lsu_misalign_o,
    output logic            data_req_o,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [XLEN-1:0] data_addr_o,
    output logic [XLEN-1:0] data_wdata_o,
    input  logic            data_gnt_i,
    input  logic            data_rvalid_i,
    input  logic [XLEN-1:0] data_rdata_i
);

    lsu_state_t      state, state_nxt;
    logic [XLEN-1:0] addr_p1, wdata_p1, addr_fix;
    logic [2:0]      size_p1;
    logic            we_p1;
    logic            is_word, is_half, trap, accept;
    logic [3:0]      be_a;
    logic [XLEN-1:0] wdata_a, rdata_a;

    assign is_word = (norm_size(lsu_size_i) == MEM_ACCESS_WORD);
    assign is_half = (lsu_size_i == MEM_ACCESS_HALF) || (lsu_size_i == MEM_ACCESS_UHALF);

`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = is_word ? (lsu_addr_i[1:0] != 2'b00) : (is_half & lsu_addr_i[0]);
    assign trap       = (state == IDLE) & lsu_req_i & ~lsu_kill_i & misaligned;
    assign addr_fix   = lsu_addr_i;
`else
    // Misaligned low address bits are silently cleared and the access proceeds.
    assign trap     = 1'b0;
    assign addr_fix = {lsu_addr_i[XLEN-1:2],
                       is_word ? 2'b00 : {lsu_addr_i[1], lsu_addr_i[0] & ~is_half}};
`endif

    assign lsu_misalign_o = trap;
    assign accept         = (state == IDLE) & lsu_req_i & ~lsu_kill_i & ~trap;

    // Request capture stage
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state    <= IDLE;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            size_p1  <= MEM_ACCESS_WORD;
            we_p1    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_p1  <= addr_fix;
                wdata_p1 <= lsu_wdata_i;
                size_p1  <= lsu_size_i;
                we_p1    <= lsu_we_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = REQ;
            REQ: begin
                if (data_gnt_i)      state_nxt = lsu_kill_i ? DRAIN : RESP;
                else if (lsu_kill_i) state_nxt = IDLE;
            end
            RESP: begin
                // A response arriving with a kill still closes the transaction.
                if (data_rvalid_i)   state_nxt = IDLE;
                else if (lsu_kill_i) state_nxt = DRAIN;
            end
            DRAIN: if (data_rvalid_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    miriscv_lsu_align #(.XLEN(XLEN)) u_align (
        .size      (size_p1),
        .addr_lo   (addr_p1[1:0]),
        .wdata     (wdata_p1),
        .rdata     (data_rdata_i),
        .be        (be_a),
        .wdata_rep (wdata_a),
        .rdata_ext (rdata_a)
    );

    // Memory request / response stage
    assign data_req_o   = (state == REQ);
    assign data_we_o    = data_req_o & we_p1;
    assign data_be_o    = data_req_o ? be_a : 4'b0000;
    assign data_addr_o  = data_req_o ? {addr_p1[XLEN-1:2], 2'b00} : '0;
    assign data_wdata_o = data_req_o ? wdata_a : '0;

    assign lsu_rvalid_o = (state == RESP) & data_rvalid_i & ~lsu_kill_i;
    assign lsu_rdata_o  = (lsu_rvalid_o & ~we_p1) ? rdata_a : '0;

    assign lsu_stall_o = arstn_i & ((state == REQ) | (state == DRAIN) |
                         (lsu_req_i & ~lsu_kill_i & ~((state == RESP) & data_rvalid_i) & ~trap));

endmodule

// File: tb/tb_miriscv_lsu.sv
// Randomized bench for miriscv_lsu (default build) against a transaction-level reference model.
module tb_miriscv_lsu;
    import miriscv_decode_pkg::*;

    logic        clk = 1'b0;
    logic        arstn_i, lsu_req_i, lsu_we_i, lsu_kill_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_stall_o, lsu_rvalid_o, lsu_misalign_o;
    logic [31:0] lsu_rdata_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    miriscv_lsu #(.XLEN(32)) dut (
        .clk_i          (clk),
        .arstn_i        (arstn_i),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_kill_i     (lsu_kill_i),
        .lsu_stall_o    (lsu_stall_o),
        .lsu_rvalid_o   (lsu_rvalid_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_misalign_o (lsu_misalign_o),
        .data_req_o     (data_req_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_rdata_i   (data_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] size);
        if (size == MEM_ACCESS_HALF || size == MEM_ACCESS_UHALF) return 2;
        if (size == MEM_ACCESS_BYTE || size == MEM_ACCESS_UBYTE) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] eff_addr(input logic [2:0] size, input logic [31:0] addr);
        return addr - (addr % nbytes(size));
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] size, input logic [31:0] addr);
        logic [31:0] ea = eff_addr(size, addr);
        return 4'(((1 << nbytes(size)) - 1) << ea[1:0]);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] size, input logic [31:0] wdata);
        if (nbytes(size) == 1) return {24'd0, wdata[7:0]} * 32'h0101_0101;
        if (nbytes(size) == 2) return {16'd0, wdata[15:0]} * 32'h0001_0001;
        return wdata;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic we, input logic [2:0] size,
                                              input logic [31:0] addr, input logic [31:0] rdata);
        int n = nbytes(size);
        logic [31:0] ea = eff_addr(size, addr);
        logic [31:0] mask, v;
        if (we) return 32'd0;
        if (n == 4) return rdata;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (rdata >> (8 * ea[1:0])) & mask;
        if ((size == MEM_ACCESS_BYTE || size == MEM_ACCESS_HALF) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic quiet_inputs();
        lsu_req_i = 1'b0; lsu_kill_i = 1'b0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = $urandom;
    endtask

    task automatic drive_op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
        lsu_addr_i = addr; lsu_wdata_i = wdata; lsu_kill_i = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(posedge clk); #1;
        drive_op(we, size, addr, wdata);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        @(negedge clk);
        check("issue_stall", 32'(lsu_stall_o), 1);
        check("issue_req", 32'(data_req_o), 0);
        check("issue_misalign", 32'(lsu_misalign_o), 0);
    endtask

    task automatic run_op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gnt_wait, input int rv_wait);
        issue(we, size, addr, wdata);
        for (int k = 0; k <= gnt_wait; k++) begin
            @(posedge clk); #1;
            data_gnt_i = (k == gnt_wait); data_rdata_i = $urandom;
            @(negedge clk);
            check("req_valid", 32'(data_req_o), 1);
            check("req_we", 32'(data_we_o), 32'(we));
            check("req_be", 32'(data_be_o), 32'(exp_be(size, addr)));
            check("req_addr", data_addr_o, {addr[31:2], 2'b00});
            check("req_wdata", data_wdata_o, exp_wdata(size, wdata));
            check("req_stall", 32'(lsu_stall_o), 1);
            check("req_rvalid", 32'(lsu_rvalid_o), 0);
        end
        for (int k = 0; k <= rv_wait; k++) begin
            @(posedge clk); #1;
            data_gnt_i = 1'b0; data_rvalid_i = (k == rv_wait);
            data_rdata_i = (k == rv_wait) ? rdata : $urandom;
            @(negedge clk);
            check("resp_req", 32'(data_req_o), 0);
            check("resp_rvalid", 32'(lsu_rvalid_o), 32'(k == rv_wait));
            check("resp_stall", 32'(lsu_stall_o), 32'(k != rv_wait));
            if (k == rv_wait) check("resp_rdata", lsu_rdata_o, exp_rdata(we, size, addr, rdata));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            quiet_inputs();
            data_gnt_i = 1'($urandom); data_rvalid_i = 1'($urandom);
            @(negedge clk);
            check("idle_req", 32'(data_req_o), 0);
            check("idle_rvalid", 32'(lsu_rvalid_o), 0);
            check("idle_rdata", lsu_rdata_o, 0);
            check("idle_stall", 32'(lsu_stall_o), 0);
        end
    endtask

    // Drain phase: a new op is held on the inputs but must not be issued until rvalid.
    task automatic drain(input int rv_wait, input logic [2:0] nsize, input logic [31:0] naddr);
        for (int k = 0; k <= rv_wait; k++) begin
            @(posedge clk); #1;
            drive_op(1'b0, nsize, naddr, 32'd0);
            data_gnt_i = 1'b0; data_rvalid_i = (k == rv_wait); data_rdata_i = $urandom;
            @(negedge clk);
            check("drain_req", 32'(data_req_o), 0);
            check("drain_rvalid", 32'(lsu_rvalid_o), 0);
            check("drain_stall", 32'(lsu_stall_o), 1);
        end
    endtask

    // mode 0: kill in REQ without gnt; 1: kill together with gnt; 2: kill in RESP
    task automatic kill_op(input int mode, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input int rv_wait);
        logic [2:0]  nsize = 3'($urandom_range(0, 7));
        logic [31:0] naddr = $urandom;
        issue(we, size, addr, $urandom);
        @(posedge clk); #1;
        lsu_kill_i = (mode != 2); data_gnt_i = (mode != 0);
        @(negedge clk);
        check("kreq_valid", 32'(data_req_o), 1);
        check("kreq_stall", 32'(lsu_stall_o), 1);
        check("kreq_rvalid", 32'(lsu_rvalid_o), 0);
        if (mode == 0) begin
            idle_cycles(1);
        end else begin
            if (mode == 2) begin
                @(posedge clk); #1;
                lsu_req_i = 1'b0; lsu_kill_i = 1'b1; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
                @(negedge clk);
                check("kresp_rvalid", 32'(lsu_rvalid_o), 0);
                check("kresp_req", 32'(data_req_o), 0);
            end
            drain(rv_wait, nsize, naddr);
            run_op(1'b0, nsize, naddr, 32'd0, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        arstn_i = 1'b0;
        quiet_inputs();
        drive_op(1'b1, MEM_ACCESS_WORD, 32'h0000_1000, 32'h1234_5678);
        lsu_size_i = MEM_ACCESS_WORD;
        repeat (3) begin
            @(negedge clk);
            check("rst_stall", 32'(lsu_stall_o), 0);
            check("rst_req", 32'(data_req_o), 0);
            check("rst_be", 32'(data_be_o), 0);
            check("rst_rvalid", 32'(lsu_rvalid_o), 0);
            check("rst_rdata", lsu_rdata_o, 0);
            check("rst_misalign", 32'(lsu_misalign_o), 0);
        end
        @(posedge clk); #1;
        arstn_i = 1'b1;
        quiet_inputs();
        idle_cycles(2);

        run_op(1'b0, MEM_ACCESS_BYTE, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 0);
        check("tp1_rdata", lsu_rdata_o, 32'hFFFF_FF80);
        run_op(1'b1, MEM_ACCESS_HALF, 32'h0000_2002, 32'hDEAD_BEEF, 32'hAAAA_5555, 3, 0);
        run_op(1'b0, MEM_ACCESS_UHALF, 32'h0000_0010, 32'd0, 32'h1234_9ABC, 0, 0);
        check("tp3_uhalf", lsu_rdata_o, 32'h0000_9ABC);
        run_op(1'b0, MEM_ACCESS_HALF, 32'h0000_0010, 32'd0, 32'h1234_9ABC, 0, 0);
        check("tp3_half", lsu_rdata_o, 32'hFFFF_9ABC);
        kill_op(2, 1'b0, MEM_ACCESS_WORD, 32'h0000_4000, 1);
        kill_op(0, 1'b1, MEM_ACCESS_BYTE, 32'h0000_4001, 0);
        kill_op(1, 1'b0, MEM_ACCESS_HALF, 32'h0000_4002, 2);
        run_op(1'b0, MEM_ACCESS_WORD, 32'h0000_3001, 32'd0, 32'hCAFE_F00D, 1, 1);
        run_op(1'b0, 3'd6, 32'h0000_5006, 32'd0, 32'h0BAD_BEEF, 0, 0);

        // Reset while a request is pending.
        issue(1'b0, MEM_ACCESS_WORD, 32'h0000_6000, 32'd0);
        @(posedge clk); #1;
        arstn_i = 1'b0; data_gnt_i = 1'b0;
        @(negedge clk);
        check("mrst_stall", 32'(lsu_stall_o), 0);
        @(posedge clk); #1;
        arstn_i = 1'b1;
        quiet_inputs();
        @(negedge clk);
        check("mrst_req", 32'(data_req_o), 0);
        check("mrst_we", 32'(data_we_o), 0);
        check("mrst_be", 32'(data_be_o), 0);
        check("mrst_addr", data_addr_o, 0);
        check("mrst_wdata", data_wdata_o, 0);
        check("mrst_stall2", 32'(lsu_stall_o), 0);
        run_op(1'b0, MEM_ACCESS_WORD, 32'h0000_6004, 32'd0, 32'h1357_9BDF, 0, 0);

        for (int i = 0; i < 150; i++) begin
            int          r  = $urandom_range(0, 9);
            logic        we = 1'($urandom);
            logic [2:0]  sz = 3'($urandom_range(0, 7));
            logic [31:0] ad = $urandom;
            if (r < 8)
                run_op(we, sz, ad, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            else
                kill_op($urandom_range(0, 2), we, sz, ad, $urandom_range(0, 3));
            idle_cycles($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
